encode_16_4_arb: RTL

Registered 16-to-4 encoder/arbiter, the encode-side counterpart of the datapath's 4-to-16 select decoder. It takes up to 16 one-hot-intended request lines (register "out" enables, port requests), grants exactly one, and presents both the 4-bit index and the matching one-hot grant. The grant is held until the owner releases it, so the bus mux sees one stable selector for the whole transfer.

---
 rtl/encode_16_4_arb_if.sv | 28 ++
 rtl/encode_16_4_arb.sv | 96 +++++++++
 2 files changed

// File: rtl/encode_16_4_arb_if.sv
// Request/grant bundle between requesters (master) and the 16-to-4 arbiter (slave).
// release_grant carries the owner's "free the grant" pulse; `release` is a reserved word.
interface encode_16_4_arb_if;
   logic [15:0] req;
   logic        release_grant;
   logic [3:0]  sel_out;
   logic [15:0] grant;
   logic        valid;
   logic        multi;

   modport master (
      output req,
      output release_grant,
      input  sel_out,
      input  grant,
      input  valid,
      input  multi
   );

   modport slave (
      input  req,
      input  release_grant,
      output sel_out,
      output grant,
      output valid,
      output multi
   );
endinterface

// File: rtl/encode_16_4_arb.sv
// Registered 16-to-4 encoder/arbiter; the grant is held until the owner releases it.
// Optional macro ENCODE_ROUND_ROBIN_EN selects round-robin instead of fixed lowest-index priority.
module encode_16_4_arb #(
   parameter logic [3:0] IDLE_SEL = 4'h0
) (
   input logic              clk,
   input logic              clr,
   encode_16_4_arb_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   state_t      state_reg;
   logic [3:0]  last_reg;
   logic [3:0]  sel_reg;
   logic [15:0] grant_reg;
   logic        valid_reg;
   logic        multi_reg;

   logic [15:0] search_vec;
   logic [3:0]  pick_offset;
   logic [3:0]  winner_next;
   logic [4:0]  req_count;
   logic        multi_next;

`ifdef ENCODE_ROUND_ROBIN_EN
   // Rotate requests so bit 0 of search_vec is index last+1; the lowest set bit then wins.
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_rot
         assign search_vec[gi] = bus.req[4'(last_reg + 4'(gi + 1))];
      end
   endgenerate
   assign winner_next = last_reg + 4'd1 + pick_offset;
`else
   assign search_vec  = bus.req;
   assign winner_next = pick_offset;
`endif

   always_comb begin
      pick_offset = 4'h0;
      for (int k = 15; k >= 0; k--) begin
         if (search_vec[k]) pick_offset = 4'(k);
      end
   end

   always_comb begin
      req_count = 5'd0;
      for (int k = 0; k < 16; k++) begin
         req_count = req_count + 5'(bus.req[k]);
      end
   end

   assign multi_next = (req_count > 5'd1);

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg <= ST_IDLE;
         last_reg  <= 4'hF;
         sel_reg   <= IDLE_SEL;
         grant_reg <= 16'h0000;
         valid_reg <= 1'b0;
         multi_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (bus.req != 16'h0000) begin
                  state_reg <= ST_GRANT;
                  last_reg  <= winner_next;
                  sel_reg   <= winner_next;
                  grant_reg <= 16'h0001 << winner_next;
                  valid_reg <= 1'b1;
                  multi_reg <= multi_next;
               end
            end
            ST_GRANT: begin
               // Outputs stay frozen until release; req is not looked at here.
               if (bus.release_grant) begin
                  state_reg <= ST_IDLE;
                  sel_reg   <= IDLE_SEL;
                  grant_reg <= 16'h0000;
                  valid_reg <= 1'b0;
                  multi_reg <= 1'b0;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.sel_out = sel_reg;
   assign bus.grant   = grant_reg;
   assign bus.valid   = valid_reg;
   assign bus.multi   = multi_reg;

endmodule
